// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory-port arbiter.
package mem_arb_pkg;

    localparam int RDATA_W = 48;
    localparam int ADDR_W  = 32;

    // Controller Ctrl encodings: bit 0 = multi, bit 1 = vertical.
    localparam logic [1:0] MC_SINGLE = 2'b00;
    localparam logic [1:0] MC_HORIZ  = 2'b01;
    localparam logic [1:0] MC_VERT   = 2'b11;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_BUSY,
        ARB_RECOVER
    } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// Combinational round-robin picker: the first set request at or after ptr,
// wrapping from the last port back to port 0.
module rr_pick #(
    parameter  int N  = 2,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx,
    output logic          valid
);

    // Scan distances 0..N-1 from ptr; the first requesting port found wins.
    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
        onehot = '0;
        idx    = '0;
        valid  = 1'b0;
        for (int d = 0; d < N; d++) begin
            for (int c = 0; c < N; c++) begin
                if (!valid && req[c] && (c == ((int'(ptr) + d) % N))) begin
                    valid     = 1'b1;
                    idx       = IW'(c);
                    onehot[c] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory controller between N_REQ requesters. A round-robin winner
// is latched, the controller is enabled until it signals completion or a
// timeout expires, the result is returned with a one-cycle ACK, and ENABLE is
// held low for RECOVER_CYC cycles so the controller can return to idle.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int N_REQ       = 2,
    parameter int TIMEOUT_CYC = 64,
    parameter int RECOVER_CYC = 1
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic [N_REQ-1:0]          REQ,
    input  logic [2*N_REQ-1:0]        REQ_CTRL,
    input  logic [ADDR_W*N_REQ-1:0]   REQ_ADDR,
    output logic [N_REQ-1:0]          GNT,
    output logic [N_REQ-1:0]          ACK,
    output logic                      ERR,
    output logic [RDATA_W-1:0]        RDATA,
    output logic                      BUSY,
    output logic                      MC_ENABLE,
    output logic [1:0]                MC_CTRL,
    output logic [ADDR_W-1:0]         MC_ADDRESS,
    input  logic [RDATA_W-1:0]        MC_READ,
    input  logic                      MC_DONE
);

    localparam int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;
    localparam int REC_W = $clog2(RECOVER_CYC) + 1;

    arb_state_e          state_q, state_d;
    logic [N_REQ-1:0]    gnt_q, gnt_d;
    logic [N_REQ-1:0]    ack_q, ack_d;
    logic                err_q, err_d;
    logic [RDATA_W-1:0]  rdata_q, rdata_d;
    logic                busy_q, busy_d;
    logic                en_q, en_d;
    logic [1:0]          ctrl_q, ctrl_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [REC_W-1:0]    rec_q, rec_d;
    logic [IW-1:0]       rr_ptr_q, rr_ptr_d;

    logic [N_REQ-1:0]    pick_onehot;
    logic [IW-1:0]       pick_idx;
    logic                pick_valid;

    rr_pick #(
        .N (N_REQ)
    ) u_rr_pick (
        .req    (REQ),
        .ptr    (rr_ptr_q),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .valid  (pick_valid)
    );

    // Next-state and datapath: arbitration in IDLE, completion/timeout in BUSY,
    // enable-low spacing in RECOVER.
    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        ack_d    = '0;
        err_d    = 1'b0;
        rdata_d  = rdata_q;
        en_d     = en_q;
        ctrl_d   = ctrl_q;
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        rec_d    = rec_q;
        rr_ptr_d = rr_ptr_q;

        case (state_q)
            ARB_IDLE: begin
                if (pick_valid) begin
                    gnt_d = pick_onehot;
                    for (int i = 0; i < N_REQ; i++) begin
                        if (pick_onehot[i]) begin
                            addr_d = REQ_ADDR[i*ADDR_W +: ADDR_W];
                            ctrl_d = REQ_CTRL[2*i +: 2];
                        end
                    end
                    en_d     = 1'b1;
                    cnt_d    = '0;
                    rr_ptr_d = (pick_idx == IW'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
                    state_d  = ARB_BUSY;
                end
            end

            ARB_BUSY: begin
                cnt_d = cnt_q + 1'b1;
                // Completion takes priority over a timeout landing on the same edge.
                if (MC_DONE) begin
                    rdata_d = MC_READ;
                    ack_d   = gnt_q;
                    gnt_d   = '0;
                    en_d    = 1'b0;
                    rec_d   = '0;
                    state_d = ARB_RECOVER;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    rdata_d = '0;
                    ack_d   = gnt_q;
                    err_d   = 1'b1;
                    gnt_d   = '0;
                    en_d    = 1'b0;
                    rec_d   = '0;
                    state_d = ARB_RECOVER;
                end
            end

            ARB_RECOVER: begin
                en_d = 1'b0;
                if (rec_q == REC_W'(RECOVER_CYC - 1)) begin
                    state_d = ARB_IDLE;
                end else begin
                    rec_d = rec_q + 1'b1;
                end
            end

            default: begin
                state_d = ARB_IDLE;
            end
        endcase

        busy_d = (state_d != ARB_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (RESET) begin
            state_q  <= ARB_IDLE;
            gnt_q    <= '0;
            ack_q    <= '0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
            busy_q   <= 1'b0;
            en_q     <= 1'b0;
            ctrl_q   <= MC_SINGLE;
            addr_q   <= '0;
            cnt_q    <= '0;
            rec_q    <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
            busy_q   <= busy_d;
            en_q     <= en_d;
            ctrl_q   <= ctrl_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            rec_q    <= rec_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign GNT        = gnt_q;
    assign ACK        = ack_q;
    assign ERR        = err_q;
    assign RDATA      = rdata_q;
    assign BUSY       = busy_q;
    assign MC_ENABLE  = en_q;
    assign MC_CTRL    = ctrl_q;
    assign MC_ADDRESS = addr_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus random
// transactions, checked against a transaction-level model (pending-request
// set, round-robin pointer, expected completion cycle).
module tb_mem_port_arbiter;

    localparam int N_REQ       = 2;
    localparam int TIMEOUT_CYC = 64;
    localparam int RECOVER_CYC = 3;

    logic         CLK = 1'b0;
    logic         RESET = 1'b1;
    logic [1:0]   REQ = '0;
    logic [3:0]   REQ_CTRL = '0;
    logic [63:0]  REQ_ADDR = '0;
    logic [1:0]   GNT;
    logic [1:0]   ACK;
    logic         ERR;
    logic [47:0]  RDATA;
    logic         BUSY;
    logic         MC_ENABLE;
    logic [1:0]   MC_CTRL;
    logic [31:0]  MC_ADDRESS;
    logic [47:0]  MC_READ = '0;
    logic         MC_DONE = 1'b0;

    mem_port_arbiter #(
        .N_REQ       (N_REQ),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .RECOVER_CYC (RECOVER_CYC)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .REQ        (REQ),
        .REQ_CTRL   (REQ_CTRL),
        .REQ_ADDR   (REQ_ADDR),
        .GNT        (GNT),
        .ACK        (ACK),
        .ERR        (ERR),
        .RDATA      (RDATA),
        .BUSY       (BUSY),
        .MC_ENABLE  (MC_ENABLE),
        .MC_CTRL    (MC_CTRL),
        .MC_ADDRESS (MC_ADDRESS),
        .MC_READ    (MC_READ),
        .MC_DONE    (MC_DONE)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state.
    int          rr_ptr;
    logic [1:0]  pending;
    logic [47:0] last_rdata;
    logic [1:0]  last_gnt;
    bit          keep_addr;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock and sample just after the edge.
    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    // Round-robin choice: first pending port at or after ptr, wrapping.
    function automatic int pick(input logic [1:0] req, input int ptr);
        logic [1:0] m;
        for (int i = 0; i < N_REQ; i++) begin
            m = req >> ((ptr + i) % N_REQ);
            if (m[0]) return (ptr + i) % N_REQ;
        end
        return 0;
    endfunction

    task automatic rand_inputs;
        REQ_ADDR = {$urandom, $urandom};
        REQ_CTRL = 4'($urandom);
    endtask

    task automatic do_reset;
        RESET   = 1'b1;
        REQ     = '0;
        MC_DONE = 1'b0;
        MC_READ = '0;
        rand_inputs();
        tick();
        tick();
        RESET      = 1'b0;
        rr_ptr     = 0;
        pending    = '0;
        last_rdata = '0;
    endtask

    // One full transaction: optional idle gap, grant, BUSY phase ending in
    // completion (done_dly cycles in, -1 = never) or timeout, then recovery.
    task automatic txn(input logic [1:0] new_req, input int gap, input int done_dly,
                       input logic [47:0] rd, input bit drop, input logic [1:0] late_req);
        int         w;
        logic [1:0] exp_gnt;
        logic [31:0] exp_addr;
        logic [1:0] exp_ctrl;
        bit         done_hit;

        if (pending == 2'b00) begin
            for (int g = 0; g < gap; g++) begin
                REQ     = '0;
                MC_DONE = 1'($urandom);
                rand_inputs();
                tick();
                check("idle_en", 64'(MC_ENABLE), 64'd0);
                check("idle_ack", 64'(ACK), 64'd0);
                check("idle_busy", 64'(BUSY), 64'd0);
            end
        end

        pending = pending | new_req;
        REQ     = pending;
        MC_DONE = 1'($urandom);
        if (!keep_addr) rand_inputs();
        w        = pick(pending, rr_ptr);
        exp_gnt  = 2'(1 << w);
        exp_addr = 32'(REQ_ADDR >> (w * 32));
        exp_ctrl = 2'(REQ_CTRL >> (w * 2));
        tick();
        last_gnt = GNT;
        check("grant_gnt", 64'(GNT), 64'(exp_gnt));
        check("grant_en", 64'(MC_ENABLE), 64'd1);
        check("grant_addr", 64'(MC_ADDRESS), 64'(exp_addr));
        check("grant_ctrl", 64'(MC_CTRL), 64'(exp_ctrl));
        check("grant_busy", 64'(BUSY), 64'd1);
        check("grant_ack", 64'(ACK), 64'd0);
        rr_ptr = (w + 1) % N_REQ;

        for (int k = 0; k < TIMEOUT_CYC; k++) begin
            rand_inputs();
            if (drop) REQ = pending & ~exp_gnt;
            MC_DONE = (k == done_dly);
            MC_READ = (k == done_dly) ? rd : {16'($urandom), $urandom};
            tick();
            if (k == done_dly || k == TIMEOUT_CYC - 1) begin
                done_hit   = (k == done_dly);
                last_rdata = done_hit ? rd : 48'd0;
                check("end_ack", 64'(ACK), 64'(exp_gnt));
                check("end_err", 64'(ERR), 64'(!done_hit));
                check("end_rdata", 64'(RDATA), 64'(last_rdata));
                check("end_en", 64'(MC_ENABLE), 64'd0);
                check("end_gnt", 64'(GNT), 64'd0);
                check("end_busy", 64'(BUSY), 64'd1);
                break;
            end else begin
                check("busy_ack", 64'(ACK), 64'd0);
                check("busy_en", 64'(MC_ENABLE), 64'd1);
                check("busy_gnt", 64'(GNT), 64'(exp_gnt));
                check("busy_addr", 64'(MC_ADDRESS), 64'(exp_addr));
                check("busy_ctrl", 64'(MC_CTRL), 64'(exp_ctrl));
            end
        end

        pending = (pending & ~exp_gnt) | late_req;
        REQ     = pending;
        for (int j = 0; j < RECOVER_CYC; j++) begin
            MC_DONE = 1'($urandom);
            MC_READ = {16'($urandom), $urandom};
            rand_inputs();
            tick();
            check("rec_ack", 64'(ACK), 64'd0);
            check("rec_err", 64'(ERR), 64'd0);
            check("rec_en", 64'(MC_ENABLE), 64'd0);
            check("rec_gnt", 64'(GNT), 64'd0);
            check("rec_busy", 64'(BUSY), 64'(j < RECOVER_CYC - 1));
            check("rec_rdata", 64'(RDATA), 64'(last_rdata));
        end
        MC_DONE = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int dly;
        keep_addr = 1'b0;
        last_gnt  = '0;

        // Reset values.
        do_reset();
        check("rst_gnt", 64'(GNT), 64'd0);
        check("rst_ack", 64'(ACK), 64'd0);
        check("rst_err", 64'(ERR), 64'd0);
        check("rst_rdata", 64'(RDATA), 64'd0);
        check("rst_en", 64'(MC_ENABLE), 64'd0);
        check("rst_ctrl", 64'(MC_CTRL), 64'd0);
        check("rst_addr", 64'(MC_ADDRESS), 64'd0);
        check("rst_busy", 64'(BUSY), 64'd0);

        // Single request from port 0 with a fixed address.
        keep_addr = 1'b1;
        REQ_ADDR  = {32'hdead_beef, 32'h0002_0005};
        REQ_CTRL  = 4'b1100;
        txn(2'b01, 0, 3, 48'h0000_0000_1234, 1'b0, 2'b00);
        check("single_addr", 64'(MC_ADDRESS), 64'h0002_0005);
        keep_addr = 1'b0;

        // Contention: both ports requesting continuously.
        do_reset();
        for (int n = 0; n < 4; n++) begin
            txn(2'b11, 0, n + 1, {16'($urandom), $urandom}, 1'b0, 2'b11);
            check("contend_gnt", 64'(last_gnt), (n % 2 == 0) ? 64'd1 : 64'd2);
        end

        // Timeout on port 1.
        do_reset();
        txn(2'b10, 2, -1, 48'h0bad_0bad_0bad, 1'b0, 2'b00);

        // Completion coinciding with the timeout edge.
        do_reset();
        txn(2'b01, 0, TIMEOUT_CYC - 1, 48'hfeed_f00d_cafe, 1'b0, 2'b00);

        // Port 0 held: recovery spacing between back-to-back transactions.
        do_reset();
        for (int n = 0; n < 3; n++) begin
            txn(2'b01, 0, 0, {16'($urandom), $urandom}, 1'b0, 2'b01);
        end

        // Reset two cycles into BUSY; the first grant afterwards goes to port 0.
        do_reset();
        txn(2'b10, 0, 1, 48'h1, 1'b0, 2'b00);
        REQ = 2'b01;
        tick();
        check("mid_grant", 64'(GNT), 64'd1);
        REQ = 2'b00;
        tick();
        tick();
        RESET = 1'b1;
        tick();
        check("mid_rst_gnt", 64'(GNT), 64'd0);
        check("mid_rst_en", 64'(MC_ENABLE), 64'd0);
        check("mid_rst_ack", 64'(ACK), 64'd0);
        check("mid_rst_busy", 64'(BUSY), 64'd0);
        RESET      = 1'b0;
        rr_ptr     = 0;
        pending    = '0;
        last_rdata = '0;
        for (int g = 0; g < 3; g++) begin
            MC_DONE = 1'b1;
            tick();
            check("post_rst_ack", 64'(ACK), 64'd0);
        end
        MC_DONE = 1'b0;
        txn(2'b11, 0, 2, 48'h55, 1'b0, 2'b00);
        check("post_rst_first", 64'(last_gnt), 64'd1);
        txn(2'b00, 0, 0, 48'h66, 1'b0, 2'b00);

        // Random traffic.
        do_reset();
        for (int n = 0; n < 40; n++) begin
            logic [1:0] nr;
            logic [1:0] lr;
            nr = 2'($urandom);
            if (pending == 2'b00 && nr == 2'b00) nr = 2'(1 << $urandom_range(0, 1));
            case ($urandom_range(0, 15))
                0:       dly = -1;
                1:       dly = TIMEOUT_CYC - 1;
                default: dly = $urandom_range(0, 11);
            endcase
            lr = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom);
            txn(nr, $urandom_range(0, 3), dly, {16'($urandom), $urandom},
                1'($urandom), lr);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
